// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini SRC control unit: opcodes, ALU codes,
// sequencer states and the packed control-line bundle.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH0 = 3'd1,
    S_FETCH1 = 3'd2,
    S_FETCH2 = 3'd3,
    S_EXEC   = 3'd4,
    S_PAUSE  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef struct packed {
    logic       run;
    logic [4:0] operation;
    logic write, read, con_in, outport_in, lo_in, hi_in, z_in, y_in, ir_in;
    logic mdr_in, mar_in, inc_pc, pc_in, r_out, r_in, grc, grb, gra;
    logic inport_out, lo_out, hi_out, ba_out, c_out, mdr_out, zlow_out, zhigh_out, pc_out;
  } ctrl_t;

  // Final execute step (T3..T7) of each opcode; single-step opcodes end at T3.
  function automatic logic [2:0] last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:                            last_step = 3'd7;
      OP_MUL, OP_DIV, OP_BR:                   last_step = 3'd6;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI: last_step = 3'd5;
      OP_NEG, OP_NOT:                          last_step = 3'd4;
      default:                                 last_step = 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Moore output decode: maps (state, step, opcode, CON FF) to every datapath
// control line. Purely combinational.
module control_decode
  import cpu_pkg::*;
(
  input  logic [2:0]  i_state,
  input  logic [2:0]  i_step,
  input  logic [4:0]  i_opcode,
  input  logic        i_con_ff,
  output logic [32:0] o_ctrl
);

  ctrl_t w_ctrl;
  logic  w_is_imm;

  assign w_is_imm = (i_opcode == OP_ADDI) || (i_opcode == OP_ANDI) || (i_opcode == OP_ORI);
  assign o_ctrl   = w_ctrl;

  always_comb begin
    w_ctrl = '0;
    case (state_t'(i_state))
      S_FETCH0: begin
        w_ctrl.run = 1'b1; w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1;
        w_ctrl.inc_pc = 1'b1; w_ctrl.z_in = 1'b1; w_ctrl.operation = ALU_ADD;
      end
      S_FETCH1: begin
        w_ctrl.run = 1'b1; w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in = 1'b1;
        w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1;
      end
      S_FETCH2: begin
        w_ctrl.run = 1'b1; w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1;
      end
      S_EXEC: begin
        w_ctrl.run = 1'b1;
        case (i_opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (i_step)
              3'd3: begin w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.y_in = 1'b1; end
              3'd4: begin
                if (w_is_imm) begin
                  w_ctrl.c_out = 1'b1;
                end else begin
                  w_ctrl.grc = 1'b1; w_ctrl.r_out = 1'b1;
                end
                w_ctrl.operation = i_opcode; w_ctrl.z_in = 1'b1;
              end
              3'd5: begin w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
              default: w_ctrl.run = 1'b1;
            endcase
          end
          // ldi, ld and st share the effective-address computation in T3/T4.
          OP_LDI, OP_LD, OP_ST: begin
            case (i_step)
              3'd3: begin w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1; end
              3'd4: begin w_ctrl.c_out = 1'b1; w_ctrl.operation = ALU_ADD; w_ctrl.z_in = 1'b1; end
              3'd5: begin
                w_ctrl.zlow_out = 1'b1;
                if (i_opcode == OP_LDI) begin
                  w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
                end else begin
                  w_ctrl.mar_in = 1'b1;
                end
              end
              3'd6: begin
                w_ctrl.mdr_in = 1'b1;
                if (i_opcode == OP_LD) begin
                  w_ctrl.read = 1'b1;
                end else begin
                  w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1;
                end
              end
              3'd7: begin
                if (i_opcode == OP_LD) begin
                  w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
                end else begin
                  w_ctrl.write = 1'b1;
                end
              end
              default: w_ctrl.run = 1'b1;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (i_step)
              3'd3: begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.y_in = 1'b1; end
              3'd4: begin
                w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1;
                w_ctrl.operation = i_opcode; w_ctrl.z_in = 1'b1;
              end
              3'd5: begin w_ctrl.zlow_out = 1'b1; w_ctrl.lo_in = 1'b1; end
              3'd6: begin w_ctrl.zhigh_out = 1'b1; w_ctrl.hi_in = 1'b1; end
              default: w_ctrl.run = 1'b1;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (i_step)
              3'd3: begin
                w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1;
                w_ctrl.operation = i_opcode; w_ctrl.z_in = 1'b1;
              end
              3'd4: begin w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
              default: w_ctrl.run = 1'b1;
            endcase
          end
          // CON FF is loaded in T3 and only consulted in T6.
          OP_BR: begin
            case (i_step)
              3'd3: begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.con_in = 1'b1; end
              3'd4: begin w_ctrl.pc_out = 1'b1; w_ctrl.y_in = 1'b1; end
              3'd5: begin w_ctrl.c_out = 1'b1; w_ctrl.operation = ALU_ADD; w_ctrl.z_in = 1'b1; end
              3'd6: begin w_ctrl.zlow_out = i_con_ff; w_ctrl.pc_in = i_con_ff; end
              default: w_ctrl.run = 1'b1;
            endcase
          end
          OP_JR:   begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.pc_in = 1'b1; end
          OP_IN:   begin w_ctrl.inport_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
          OP_OUT:  begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.outport_in = 1'b1; end
          OP_MFHI: begin w_ctrl.hi_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
          OP_MFLO: begin w_ctrl.lo_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
          default: w_ctrl.run = 1'b1;
        endcase
      end
      default: w_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch/execute sequencing with memory
// handshake stretching, pause at instruction boundaries and halt.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  input  logic        stop,
  output logic PCout, ZHighOut, ZLowOut, MDRout, Cout, BAout, HIout, LOout, InPortout,
  output logic Gra, Grb, Grc, Rin, Rout,
  output logic PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin,
  output logic Read, Write,
  output logic [4:0] operation,
  output logic Run
);

  state_t     r_state, w_next_state;
  logic [2:0] r_step, w_next_step;
  logic [4:0] w_opcode;
  logic       w_mem_step;
  ctrl_t      w_ctrl;
  logic       w_unused_ir;

  assign w_opcode    = ir[31:27];
  assign w_unused_ir = ^ir[26:0];
  assign w_mem_step  = ((w_opcode == OP_LD) && (r_step == 3'd6)) ||
                       ((w_opcode == OP_ST) && (r_step == 3'd7));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_RESET;
      r_step  <= 3'd3;
    end else begin
      r_state <= w_next_state;
      r_step  <= w_next_step;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_step  = r_step;
    case (r_state)
      S_RESET:  w_next_state = S_FETCH0;
      S_FETCH0: w_next_state = S_FETCH1;
      S_FETCH1: w_next_state = mem_ready ? S_FETCH2 : S_FETCH1;
      S_FETCH2: begin
        w_next_state = S_EXEC;
        w_next_step  = 3'd3;
      end
      // Halt beats stop; a memory step holds until mem_ready is sampled high.
      S_EXEC: begin
        if (w_opcode == OP_HALT) begin
          w_next_state = S_HALT;
          w_next_step  = 3'd3;
        end else if (w_mem_step && !mem_ready) begin
          w_next_state = S_EXEC;
        end else if (r_step >= last_step(w_opcode)) begin
          w_next_state = stop ? S_PAUSE : S_FETCH0;
          w_next_step  = 3'd3;
        end else begin
          w_next_step  = r_step + 3'd1;
        end
      end
      S_PAUSE:  w_next_state = stop ? S_PAUSE : S_FETCH0;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_RESET;
    endcase
  end

  control_decode u_decode (
    .i_state  (r_state),
    .i_step   (r_step),
    .i_opcode (w_opcode),
    .i_con_ff (con_ff),
    .o_ctrl   (w_ctrl)
  );

  assign PCout     = w_ctrl.pc_out;
  assign ZHighOut  = w_ctrl.zhigh_out;
  assign ZLowOut   = w_ctrl.zlow_out;
  assign MDRout    = w_ctrl.mdr_out;
  assign Cout      = w_ctrl.c_out;
  assign BAout     = w_ctrl.ba_out;
  assign HIout     = w_ctrl.hi_out;
  assign LOout     = w_ctrl.lo_out;
  assign InPortout = w_ctrl.inport_out;
  assign Gra       = w_ctrl.gra;
  assign Grb       = w_ctrl.grb;
  assign Grc       = w_ctrl.grc;
  assign Rin       = w_ctrl.r_in;
  assign Rout      = w_ctrl.r_out;
  assign PCin      = w_ctrl.pc_in;
  assign IncPC     = w_ctrl.inc_pc;
  assign MARin     = w_ctrl.mar_in;
  assign MDRin     = w_ctrl.mdr_in;
  assign IRin      = w_ctrl.ir_in;
  assign Yin       = w_ctrl.y_in;
  assign Zin       = w_ctrl.z_in;
  assign HIin      = w_ctrl.hi_in;
  assign LOin      = w_ctrl.lo_in;
  assign OutPortin = w_ctrl.outport_in;
  assign CONin     = w_ctrl.con_in;
  assign Read      = w_ctrl.read;
  assign Write     = w_ctrl.write;
  assign operation = w_ctrl.operation;
  assign Run       = w_ctrl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: an instruction-level model expands each instruction into
// its expected per-cycle control words, with random memory stalls and pauses.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr, con_ff, mem_ready, stop;
  logic [31:0] ir;
  logic PCout, ZHighOut, ZLowOut, MDRout, Cout, BAout, HIout, LOout, InPortout;
  logic Gra, Grb, Grc, Rin, Rout;
  logic PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin;
  logic Read, Write, Run;
  logic [4:0] operation;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut), .MDRout(MDRout), .Cout(Cout),
    .BAout(BAout), .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin),
    .Read(Read), .Write(Write), .operation(operation), .Run(Run)
  );

  logic [32:0] obs;
  assign obs = {Run, operation, Write, Read, CONin, OutPortin, LOin, HIin, Zin, Yin, IRin,
                MDRin, MARin, IncPC, PCin, Rout, Rin, Grc, Grb, Gra, InPortout, LOout,
                HIout, BAout, Cout, MDRout, ZLowOut, ZHighOut, PCout};

  localparam logic [32:0] V_PCOUT = 33'd1 << 0,  V_ZHI   = 33'd1 << 1,  V_ZLO   = 33'd1 << 2;
  localparam logic [32:0] V_MDROUT= 33'd1 << 3,  V_COUT  = 33'd1 << 4,  V_BAOUT = 33'd1 << 5;
  localparam logic [32:0] V_HIOUT = 33'd1 << 6,  V_LOOUT = 33'd1 << 7,  V_INP   = 33'd1 << 8;
  localparam logic [32:0] V_GRA   = 33'd1 << 9,  V_GRB   = 33'd1 << 10, V_GRC   = 33'd1 << 11;
  localparam logic [32:0] V_RIN   = 33'd1 << 12, V_ROUT  = 33'd1 << 13, V_PCIN  = 33'd1 << 14;
  localparam logic [32:0] V_INCPC = 33'd1 << 15, V_MARIN = 33'd1 << 16, V_MDRIN = 33'd1 << 17;
  localparam logic [32:0] V_IRIN  = 33'd1 << 18, V_YIN   = 33'd1 << 19, V_ZIN   = 33'd1 << 20;
  localparam logic [32:0] V_HIIN  = 33'd1 << 21, V_LOIN  = 33'd1 << 22, V_OUTP  = 33'd1 << 23;
  localparam logic [32:0] V_CONIN = 33'd1 << 24, V_READ  = 33'd1 << 25, V_WRITE = 33'd1 << 26;
  localparam logic [32:0] V_RUN   = 33'd1 << 32, V_ADD   = 33'd3 << 27, V_ZERO  = 33'd0;
  localparam logic [32:0] V_F0 = V_RUN | V_PCOUT | V_MARIN | V_INCPC | V_ZIN | V_ADD;
  localparam logic [32:0] V_F1 = V_RUN | V_ZLO | V_PCIN | V_READ | V_MDRIN;

  // Expected cycle list: bit 33 marks a step that waits for mem_ready.
  logic [33:0] q[$];

  function automatic logic [32:0] opv(input logic [4:0] op);
    return {1'b0, op, 27'd0};
  endfunction

  function automatic void p(input logic [32:0] v, input logic m);
    q.push_back({m, V_RUN | v});
  endfunction

  function automatic void build(input logic [4:0] op, input logic con);
    q.delete();
    p(V_PCOUT | V_MARIN | V_INCPC | V_ZIN | V_ADD, 1'b0);
    p(V_ZLO | V_PCIN | V_READ | V_MDRIN, 1'b1);
    p(V_MDROUT | V_IRIN, 1'b0);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        p(V_GRB | V_ROUT | V_YIN, 1'b0);
        p(V_GRC | V_ROUT | opv(op) | V_ZIN, 1'b0);
        p(V_ZLO | V_GRA | V_RIN, 1'b0);
      end
      5'd12, 5'd13, 5'd14: begin
        p(V_GRB | V_ROUT | V_YIN, 1'b0);
        p(V_COUT | opv(op) | V_ZIN, 1'b0);
        p(V_ZLO | V_GRA | V_RIN, 1'b0);
      end
      5'd1: begin
        p(V_GRB | V_BAOUT | V_YIN, 1'b0);
        p(V_COUT | V_ADD | V_ZIN, 1'b0);
        p(V_ZLO | V_GRA | V_RIN, 1'b0);
      end
      5'd0, 5'd2: begin
        p(V_GRB | V_BAOUT | V_YIN, 1'b0);
        p(V_COUT | V_ADD | V_ZIN, 1'b0);
        p(V_ZLO | V_MARIN, 1'b0);
        if (op == 5'd0) begin
          p(V_READ | V_MDRIN, 1'b1);
          p(V_MDROUT | V_GRA | V_RIN, 1'b0);
        end else begin
          p(V_GRA | V_ROUT | V_MDRIN, 1'b0);
          p(V_WRITE, 1'b1);
        end
      end
      5'd15, 5'd16: begin
        p(V_GRA | V_ROUT | V_YIN, 1'b0);
        p(V_GRB | V_ROUT | opv(op) | V_ZIN, 1'b0);
        p(V_ZLO | V_LOIN, 1'b0);
        p(V_ZHI | V_HIIN, 1'b0);
      end
      5'd17, 5'd18: begin
        p(V_GRB | V_ROUT | opv(op) | V_ZIN, 1'b0);
        p(V_ZLO | V_GRA | V_RIN, 1'b0);
      end
      5'd19: begin
        p(V_GRA | V_ROUT | V_CONIN, 1'b0);
        p(V_PCOUT | V_YIN, 1'b0);
        p(V_COUT | V_ADD | V_ZIN, 1'b0);
        p(con ? (V_ZLO | V_PCIN) : V_ZERO, 1'b0);
      end
      5'd20: p(V_GRA | V_ROUT | V_PCIN, 1'b0);
      5'd22: p(V_INP | V_GRA | V_RIN, 1'b0);
      5'd23: p(V_GRA | V_ROUT | V_OUTP, 1'b0);
      5'd24: p(V_HIOUT | V_GRA | V_RIN, 1'b0);
      5'd25: p(V_LOOUT | V_GRA | V_RIN, 1'b0);
      default: p(V_ZERO, 1'b0);
    endcase
  endfunction

  // Starts at FETCH0 (#1 after an edge); ends #1 after the edge leaving the last step.
  task automatic run_instr(input logic [31:0] instr, input logic con, input int pct,
                           input int max_st, input bit fetch_st, input bit stop_req,
                           input string name);
    int idx;
    int st;
    logic [33:0] e;
    idx = 0;
    st = 0;
    build(instr[31:27], con);
    ir = instr;
    con_ff = con;
    stop = 1'b0;
    while (idx < q.size()) begin
      e = q[idx];
      checks++;
      if (obs !== e[32:0]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h want %h", name, idx, obs, e[32:0]);
      end
      if (stop_req && idx == q.size() - 2) stop = 1'b1;
      if (e[33] && (fetch_st || idx > 2) && st < max_st && $urandom_range(99) < pct) begin
        mem_ready = 1'b0;
        st++;
      end else if (e[33]) begin
        mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(1));
      end
      @(posedge clk); #1;
      if (!(e[33] && !mem_ready)) idx++;
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_reset;
    clr = 1'b1; ir = 32'd0; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== V_ZERO) begin errors++; $display("FAIL reset_held: got %h want %h", obs, V_ZERO); end
    clr = 1'b0; #1;
    checks++;
    if (obs !== V_ZERO) begin errors++; $display("FAIL reset_state: got %h want %h", obs, V_ZERO); end
    @(posedge clk); #1;
    checks++;
    if (obs !== V_F0) begin errors++; $display("FAIL reset_to_fetch0: got %h want %h", obs, V_F0); end
  endtask

  task automatic test_add;
    run_instr(32'h18918000, 1'b0, 0, 0, 1'b0, 1'b0, "add");
    checks++;
    if (obs !== V_F0) begin errors++; $display("FAIL add_cycle7: got %h want %h", obs, V_F0); end
  endtask

  task automatic test_ld_wait;
    run_instr(32'h00900065, 1'b0, 100, 2, 1'b0, 1'b0, "ld_wait");
  endtask

  task automatic test_br;
    run_instr(32'h98000000, 1'b1, 0, 0, 1'b0, 1'b0, "br_taken");
    run_instr(32'h98000000, 1'b0, 0, 0, 1'b0, 1'b0, "br_not_taken");
  endtask

  task automatic test_mul;
    run_instr(32'h81A00000, 1'b0, 0, 0, 1'b0, 1'b0, "mul");
  endtask

  task automatic test_stop_pause;
    run_instr(32'h18918000, 1'b0, 0, 0, 1'b0, 1'b1, "add_stop");
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom_range(1));
      checks++;
      if (obs !== V_ZERO) begin errors++; $display("FAIL pause_held: got %h want %h", obs, V_ZERO); end
      @(posedge clk); #1;
    end
    stop = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== V_F0) begin errors++; $display("FAIL pause_release: got %h want %h", obs, V_F0); end
  endtask

  task automatic test_halt_clr;
    run_instr(32'hD8000000, 1'b0, 0, 0, 1'b0, 1'b1, "halt");
    for (int i = 0; i < 4; i++) begin
      stop = 1'($urandom_range(1));
      checks++;
      if (obs !== V_ZERO) begin errors++; $display("FAIL halt_held: got %h want %h", obs, V_ZERO); end
      @(posedge clk); #1;
    end
    stop = 1'b0;
    clr = 1'b1; #2; clr = 1'b0; #1;
    @(posedge clk); #1;
    checks++;
    if (obs !== V_F0) begin errors++; $display("FAIL halt_clr_fetch0: got %h want %h", obs, V_F0); end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== V_F1) begin errors++; $display("FAIL fetch1_wait: got %h want %h", obs, V_F1); end
    #2 clr = 1'b1; #1;
    checks++;
    if (obs !== V_ZERO) begin errors++; $display("FAIL clr_immediate: got %h want %h", obs, V_ZERO); end
    @(posedge clk); #1;
    checks++;
    if (obs !== V_ZERO) begin errors++; $display("FAIL clr_held: got %h want %h", obs, V_ZERO); end
    clr = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== V_F0) begin errors++; $display("FAIL clr_release: got %h want %h", obs, V_F0); end
  endtask

  task automatic test_random;
    logic [4:0] op;
    logic [31:0] instr;
    bit sreq;
    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom_range(31));
      if (op == 5'd27) op = 5'd26;
      instr = {op, 27'($urandom)};
      sreq = ($urandom_range(4) == 0);
      run_instr(instr, 1'($urandom_range(1)), 30, 3, 1'b1, sreq, "random");
      if (sreq) begin
        checks++;
        if (obs !== V_ZERO) begin errors++; $display("FAIL random_pause: got %h want %h", obs, V_ZERO); end
        stop = 1'b0;
        @(posedge clk); #1;
      end
      checks++;
      if (obs !== V_F0) begin errors++; $display("FAIL random_next_fetch op %0d: got %h want %h", op, obs, V_F0); end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_ld_wait;
    test_br;
    test_mul;
    test_stop_pause;
    test_random;
    test_halt_clr;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the Mini SRC datapath: a Moore state machine that runs the fetch phase (T0–T2) and the per-opcode execute steps (T3–T7), driving every bus-select, register-enable, memory and ALU control line the datapath exposes. It sits beside the datapath, reads the IR output and the CON FF, and replaces testbench-driven control signals. A memory handshake (`mem_ready`) stretches read/write steps, and a `stop` input pauses execution between instructions.

## Interface
- `clk` in 1: single clock, all state changes on the rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `ir` in 32: IR register output; opcode `ir[31:27]`.
- `con_ff` in 1: CON FF output, sampled in branch step T6.
- `mem_ready` in 1: memory has completed the current read or write.
- `stop` in 1: pause request, honoured only at an instruction boundary.
- `PCout, ZHighOut, ZLowOut, MDRout, Cout, BAout, HIout, LOout, InPortout` out 1 each: bus source selects.
- `Gra, Grb, Grc, Rin, Rout` out 1 each: register-select logic controls.
- `PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin` out 1 each: register enables.
- `Read, Write` out 1 each: memory strobes. `Read` also selects memory data into the MDR.
- `operation` out 5: ALU opcode.
- `Run` out 1: high while the processor is executing.

## Operation
- States: `S_RESET`, `S_FETCH0`, `S_FETCH1`, `S_FETCH2`, `S_EXEC` (with a 3-bit step register holding 3..7), `S_PAUSE`, `S_HALT`.
- Every output is 0 in `S_RESET`, `S_PAUSE` and `S_HALT`. `Run` is 1 in every other state.
- Outputs are a pure decode of (state, step, `ir[31:27]`). Any signal not listed for a state or step is 0.
- Fetch phase:
  - FETCH0: `PCout`, `MARin`, `IncPC`, `Zin`, `operation`=ADD.
  - FETCH1: `ZLowOut`, `PCin`, `Read`, `MDRin`.
  - FETCH2: `MDRout`, `IRin`.
- Execute steps by opcode. `op` means `operation`=`ir[31:27]`; ADD means 5'b00011.
  - add, sub, and, or, ror, rol, shr, shra, shl:
    - T3 `Grb Rout Yin`
    - T4 `Grc Rout op Zin`
    - T5 `ZLowOut Gra Rin`
  - addi, andi, ori:
    - T3 `Grb Rout Yin`
    - T4 `Cout op Zin`
    - T5 `ZLowOut Gra Rin`
  - ldi:
    - T3 `Grb BAout Yin`
    - T4 `Cout ADD Zin`
    - T5 `ZLowOut Gra Rin`
  - ld: T3–T4 as ldi, then
    - T5 `ZLowOut MARin`
    - T6 `Read MDRin`
    - T7 `MDRout Gra Rin`
  - st: T3–T5 as ld, then
    - T6 `Gra Rout MDRin`
    - T7 `Write`
  - mul, div:
    - T3 `Gra Rout Yin`
    - T4 `Grb Rout op Zin`
    - T5 `ZLowOut LOin`
    - T6 `ZHighOut HIin`
  - neg, not:
    - T3 `Grb Rout op Zin`
    - T4 `ZLowOut Gra Rin`
  - br:
    - T3 `Gra Rout CONin`
    - T4 `PCout Yin`
    - T5 `Cout ADD Zin`
    - T6 `ZLowOut` and `PCin`, both asserted only if `con_ff`=1
  - Single-step (T3) opcodes:
    - jr: `Gra Rout PCin`
    - in: `InPortout Gra Rin`
    - out: `Gra Rout OutPortin`
    - mfhi: `HIout Gra Rin`
    - mflo: `LOout Gra Rin`
  - nop, jal and unassigned opcodes 11100–11111: T3 with no outputs asserted (nop).
  - halt: T3 asserts nothing, next state `S_HALT`.
- Transitions:
  - `S_RESET` goes to FETCH0 on the first clock edge with `clr`=0.
  - FETCH0 → FETCH1 → FETCH2 → `S_EXEC` with step=3.
  - In `S_EXEC`, the step advances until the opcode's last step. After the last step the machine goes to `S_PAUSE` if `stop`=1, otherwise to FETCH0.
  - `S_PAUSE` goes to FETCH0 in the first cycle `stop`=0.
  - `S_HALT` is left only by `clr`.
- Memory handshake: in FETCH1, ld T6 and st T7 the state holds, with `Read`/`Write` and `MDRin` held asserted, until a rising edge samples `mem_ready`=1.

## Timing
- Reset: `clr` forces `S_RESET` immediately, with all outputs 0 and the step register at 3. This applies mid-instruction and mid-wait.
- Cycle counts with `mem_ready` always 1 (fetch included):
  - 3-register ALU ops, immediate ops, ldi: 6 cycles.
  - ld, st: 8 cycles.
  - mul, div, br: 7 cycles.
  - neg, not: 5 cycles.
  - jr, in, out, mfhi, mflo, nop: 4 cycles.
- Each cycle `mem_ready`=0 in a memory step adds exactly one cycle.
- The branch decision uses `con_ff` as sampled in T6. CONin in T3 leaves two cycles of settling.
- Simultaneous events:
  - halt with `stop`=1: `S_HALT` wins.
  - `stop` asserted mid-instruction: the instruction completes first.
  - `mem_ready`=1 outside a memory step: ignored.

## Structure
- `cpu_pkg` holds:
  - 5-bit opcode localparams (ld 00000 … halt 11011, as listed above).
  - The ALU ADD code.
  - The state encoding.
- Sub-module `control_decode`: combinational mapping (state, step, opcode, `con_ff`) → output vector. The top level holds only the state and step registers and the next-state logic.

## Test plan
- add R1,R2,R3: `ir`=0x18918000 → T3 `Grb Rout Yin`; T4 `Grc Rout Zin` with `operation`=00011; T5 `ZLowOut Gra Rin`; FETCH0 on cycle 7.
- ld R1,0x65(R2): `ir`=0x00900065, `mem_ready` low for 2 cycles in T6 → `Read` and `MDRin` held for 3 cycles; instruction total 10 cycles.
- br with `ir`=0x98000000:
  - `con_ff`=1 in T6 → `PCin` and `ZLowOut` pulse once.
  - Repeat with `con_ff`=0 → no `PCin` in T6.
- mul R3,R4: `ir`=0x81A00000 → `LOin` in T5, `HIin` in T6, `operation`=10000 in T4.
- `stop`=1 during add T4 → T5 completes, `Run`=0 in `S_PAUSE`; `stop`=0 → FETCH0 next cycle.
- halt (`ir`=0xD8000000) → `Run`=0 and held; `clr` pulsed mid-FETCH1 of a later run → all outputs 0 immediately, FETCH0 one edge after release.
